complex_result_vector_collector: RTL and testbench

// Sits directly downstream of the complex matrix-by-vector engine. Gathers the per-pass
// row results (no_of_units complex words per pass) into one full result vector (out_full),

---
 rtl/complex_result_vector_collector_if.sv | 27 ++
 rtl/complex_result_vector_collector.sv | 105 ++++++++++
 tb/tb_complex_result_vector_collector.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/complex_result_vector_collector_if.sv
// Handshake/bus bundle between the result collector and its producer/consumer.
// master = stimulus side (engine + consumer), slave = the collector itself.
interface complex_result_vector_collector_if #(
    parameter int no_of_eqn_per_cluster = 3,
    parameter int element_width         = 64,
    parameter int no_of_units           = 4
);
    logic                                            start;
    logic                                            in_valid;
    logic [element_width*no_of_units-1:0]            in_data;
    logic                                            out_ack;
    logic [element_width*no_of_eqn_per_cluster-1:0]  out_full;
    logic                                            out_valid;
    logic                                            busy;
    logic [7:0]                                      chunk_count;
    logic                                            overflow;

    modport master (
        output start, in_valid, in_data, out_ack,
        input  out_full, out_valid, busy, chunk_count, overflow
    );

    modport slave (
        input  start, in_valid, in_data, out_ack,
        output out_full, out_valid, busy, chunk_count, overflow
    );
endinterface

// File: rtl/complex_result_vector_collector.sv
// Collects per-pass complex row results into one result vector, drops padding rows,
// and presents the vector with a valid/ack handshake.
module complex_result_vector_collector #(
    parameter int no_of_eqn_per_cluster = 3,
    parameter int element_width         = 64,
    parameter int no_of_units           = 4,
    parameter int NI                    = 8
) (
    input  logic clk,
    input  logic reset,
    complex_result_vector_collector_if.slave bus
);
    localparam int EQN    = no_of_eqn_per_cluster;
    localparam int W      = element_width;
    localparam int NU     = no_of_units;
    localparam int TOTAL  = EQN + NI - (EQN % NI);
    localparam int CHUNKS = TOTAL / NU;

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD, DONE} state_t;

    state_t                     state_q, state_d;
    logic [7:0]                 chunk_count_q, chunk_count_d;
    logic                       overflow_q, overflow_d;
    logic [EQN-1:0][W-1:0]      full_q, full_d;
    logic                       accept;
    logic                       last_chunk;
    logic                       clear;
    logic                       unused_in_data;

    // A chunk is taken in IDLE (same edge as start rising) or in COLLECT.
    assign accept     = bus.start && bus.in_valid && (state_q == IDLE || state_q == COLLECT)
                        && (chunk_count_q < 8'(CHUNKS));
    assign last_chunk = accept && (chunk_count_q == 8'(CHUNKS - 1));
    assign clear      = bus.start && (state_q == IDLE);
    // Padding lanes never reach out_full; fold them here so they are consciously unused.
    assign unused_in_data = ^bus.in_data;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (!bus.start) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = last_chunk ? HOLD : COLLECT;
                COLLECT: if (last_chunk) state_d = HOLD;
                HOLD:    if (bus.out_ack) state_d = DONE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        bus.out_valid = (state_q == HOLD);
        bus.busy      = (state_q == COLLECT) || (state_q == HOLD);
    end

    // Element e lives in chunk e/NU, lane NU-1-(e%NU); element 0 sits at the MSB end.
    for (genvar gi = 0; gi < EQN; gi++) begin : g_elem
        localparam int K    = gi / NU;
        localparam int LANE = NU - 1 - (gi % NU);
        assign full_d[EQN-1-gi] = (accept && chunk_count_q == 8'(K)) ? bus.in_data[W*LANE +: W]
                                : clear ? '0
                                : full_q[EQN-1-gi];
    end

    always_comb begin
        chunk_count_d = chunk_count_q;
        overflow_d    = overflow_q;
        if (!bus.start) begin
            chunk_count_d = '0;
            overflow_d    = 1'b0;
        end else begin
            if (accept) chunk_count_d = chunk_count_q + 8'd1;
            if (bus.in_valid && (state_q == HOLD || state_q == DONE)) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            full_q        <= '0;
            chunk_count_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            full_q        <= full_d;
            chunk_count_q <= chunk_count_d;
            overflow_q    <= overflow_d;
        end
    end

    assign bus.out_full    = full_q;
    assign bus.chunk_count = chunk_count_q;
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_complex_result_vector_collector.sv
// Directed + randomized bench for complex_result_vector_collector (eqn=3 and eqn=8 instances)
// against a row-queue reference model.
module tb_complex_result_vector_collector;
    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [63:0] rows_a[$];
    logic [63:0] rows_b[$];

    complex_result_vector_collector_if #(.no_of_eqn_per_cluster(3)) ifa ();
    complex_result_vector_collector_if #(.no_of_eqn_per_cluster(8)) ifb ();

    complex_result_vector_collector #(.no_of_eqn_per_cluster(3)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.slave));
    complex_result_vector_collector #(.no_of_eqn_per_cluster(8)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Rows arrive top lane first; the queue index is the row (element) number.
    function automatic void push_a(input logic [255:0] d);
        for (int j = 3; j >= 0; j--) rows_a.push_back(d[64*j +: 64]);
    endfunction
    function automatic void push_b(input logic [255:0] d);
        for (int j = 3; j >= 0; j--) rows_b.push_back(d[64*j +: 64]);
    endfunction

    function automatic logic [511:0] exp_a();
        logic [511:0] r = '0;
        for (int e = 0; e < 3 && e < rows_a.size(); e++) r[64*(3-e)-1 -: 64] = rows_a[e];
        return r;
    endfunction
    function automatic logic [511:0] exp_b();
        logic [511:0] r = '0;
        for (int e = 0; e < 8 && e < rows_b.size(); e++) r[64*(8-e)-1 -: 64] = rows_b[e];
        return r;
    endfunction

    task automatic send_a(input logic [255:0] d);
        ifa.in_valid = 1'b1;
        ifa.in_data  = d;
        tick();
        ifa.in_valid = 1'b0;
    endtask

    initial begin
        logic [255:0] d;
        logic [511:0] held;
        int gap;

        reset = 1'b0;
        ifa.start = 0; ifa.in_valid = 0; ifa.in_data = '0; ifa.out_ack = 0;
        ifb.start = 0; ifb.in_valid = 0; ifb.in_data = '0; ifb.out_ack = 0;
        tick(); tick();
        check("rst_full", ifa.out_full, 0);
        check("rst_valid", ifa.out_valid, 0);
        check("rst_busy", ifa.busy, 0);
        check("rst_count", ifa.chunk_count, 0);
        check("rst_ovf", ifa.overflow, 0);
        reset = 1'b1;
        tick();

        // Reset pulse mid-collection
        ifa.start = 1;
        send_a(rnd256());
        check("t1_count_before", ifa.chunk_count, 1);
        check("t1_busy_before", ifa.busy, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        ifa.start = 0;
        check("t1_full", ifa.out_full, 0);
        check("t1_valid", ifa.out_valid, 0);
        check("t1_count", ifa.chunk_count, 0);
        check("t1_busy", ifa.busy, 0);
        check("t1_ovf", ifa.overflow, 0);
        tick();

        // Two chunks with a 3-cycle gap
        rows_a.delete();
        ifa.start = 1;
        tick();
        check("t2_busy", ifa.busy, 1);
        check("t2_full_cleared", ifa.out_full, 0);
        d = rnd256(); push_a(d); send_a(d);
        check("t2_count1", ifa.chunk_count, 1);
        for (int i = 0; i < 3; i++) begin
            check("t2_gap_valid", ifa.out_valid, 0);
            tick();
        end
        check("t2_pre_valid", ifa.out_valid, 0);
        d = rnd256(); push_a(d); send_a(d);
        check("t2_valid", ifa.out_valid, 1);
        check("t2_full", ifa.out_full, exp_a());
        check("t2_count2", ifa.chunk_count, 2);

        // Hold without ack, then single-cycle ack
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_hold_valid", ifa.out_valid, 1);
            check("t3_hold_full", ifa.out_full, exp_a());
        end
        ifa.out_ack = 1;
        tick();
        ifa.out_ack = 0;
        check("t3_ack_valid", ifa.out_valid, 0);
        check("t3_ack_busy", ifa.busy, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_done_valid", ifa.out_valid, 0);
            check("t3_done_count", ifa.chunk_count, 2);
        end
        ifa.start = 0;
        tick();

        // Chunk arriving in HOLD sets overflow, data untouched
        rows_a.delete();
        ifa.start = 1;
        d = rnd256(); push_a(d); send_a(d);
        d = rnd256(); push_a(d); send_a(d);
        check("t4_valid", ifa.out_valid, 1);
        send_a(rnd256());
        check("t4_ovf", ifa.overflow, 1);
        check("t4_full", ifa.out_full, exp_a());
        check("t4_valid_kept", ifa.out_valid, 1);
        ifa.out_ack = 1; tick(); ifa.out_ack = 0;
        ifa.start = 0;
        tick();
        check("t4_ovf_cleared", ifa.overflow, 0);
        check("t4_full_retained", ifa.out_full, exp_a());

        // in_valid and out_ack on the same HOLD edge
        rows_a.delete();
        ifa.start = 1;
        d = rnd256(); push_a(d); send_a(d);
        d = rnd256(); push_a(d); send_a(d);
        ifa.out_ack = 1;
        send_a(rnd256());
        ifa.out_ack = 0;
        check("t4b_valid", ifa.out_valid, 0);
        check("t4b_ovf", ifa.overflow, 1);
        check("t4b_full", ifa.out_full, exp_a());
        ifa.start = 0;
        tick();
        check("t4b_ovf_cleared", ifa.overflow, 0);

        // in_valid while idle with start low is ignored
        send_a(rnd256());
        check("idle_ovf", ifa.overflow, 0);
        check("idle_count", ifa.chunk_count, 0);
        check("idle_full", ifa.out_full, exp_a());

        // Abort after chunk 0, restart with a chunk on the re-raise edge
        rows_a.delete();
        ifa.start = 1;
        d = rnd256(); push_a(d); send_a(d);
        held = exp_a();
        ifa.start = 0;
        tick();
        check("t5_abort_busy", ifa.busy, 0);
        check("t5_abort_count", ifa.chunk_count, 0);
        check("t5_abort_full", ifa.out_full, held);
        rows_a.delete();
        ifa.start = 1;
        d = rnd256(); push_a(d); send_a(d);
        check("t5_count", ifa.chunk_count, 1);
        check("t5_full", ifa.out_full, exp_a());
        d = rnd256(); push_a(d); send_a(d);
        check("t5_valid", ifa.out_valid, 1);
        check("t5_full_final", ifa.out_full, exp_a());
        ifa.out_ack = 1; tick(); ifa.out_ack = 0;
        ifa.start = 0;
        tick();

        // Randomized collections with random gaps
        for (int it = 0; it < 6; it++) begin
            rows_a.delete();
            ifa.start = 1;
            if ($urandom_range(0, 1) == 0) tick();
            for (int c = 0; c < 2; c++) begin
                gap = $urandom_range(0, 3);
                for (int g = 0; g < gap; g++) tick();
                d = rnd256(); push_a(d); send_a(d);
                check("rnd_valid", ifa.out_valid, (c == 1) ? 1 : 0);
                check("rnd_count", ifa.chunk_count, c + 1);
            end
            check("rnd_full", ifa.out_full, exp_a());
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) tick();
            ifa.out_ack = 1; tick(); ifa.out_ack = 0;
            check("rnd_ack_valid", ifa.out_valid, 0);
            ifa.start = 0;
            tick();
        end

        // Eight equations: four chunks, only the first two carry real rows
        rows_b.delete();
        ifb.start = 1;
        tick();
        for (int c = 0; c < 4; c++) begin
            d = rnd256(); push_b(d);
            ifb.in_valid = 1; ifb.in_data = d;
            tick();
            ifb.in_valid = 0;
            check("t6_valid", ifb.out_valid, (c == 3) ? 1 : 0);
            check("t6_count", ifb.chunk_count, c + 1);
        end
        check("t6_full", ifb.out_full, exp_b());
        ifb.out_ack = 1; tick(); ifb.out_ack = 0;
        check("t6_ack_valid", ifb.out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
